// File: rtl/axi4_write_arbiter_if.sv
// rtl/axi4_write_arbiter_if.sv - requester and AXI4 write-master bundle for the write arbiter
interface axi4_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_error;
    logic                          write_start;
    logic [ADDR_WIDTH-1:0]         write_addr;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          write_ready;
    logic                          write_done;
    logic                          write_error;

    // master: the arbiter side, which masters the downstream write request
    modport master (
        input  req_valid, req_addr, req_data, write_ready, write_done, write_error,
        output req_ready, req_done, req_error, write_start, write_addr, write_data
    );

    modport slave (
        output req_valid, req_addr, req_data, write_ready, write_done, write_error,
        input  req_ready, req_done, req_error, write_start, write_addr, write_data
    );
endinterface

// File: rtl/axi4_write_arbiter.sv
// rtl/axi4_write_arbiter.sv - round-robin arbiter funnelling requester writes into one AXI4 master
module axi4_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    axi4_write_arbiter_if.master    bus,
    output logic                    o_busy,
    output logic [7:0]              o_err_count
);
    localparam int IW = 3;
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          r_winner;
    logic [CW-1:0]          r_cnt;
    logic                   r_error;
    logic [NUM_REQ-1:0]     r_req_ready;
    logic [NUM_REQ-1:0]     r_req_done;
    logic [NUM_REQ-1:0]     r_req_error;
    logic                   r_write_start;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_busy;
    logic [7:0]             r_err_count;

    logic                   w_found;
    logic [IW-1:0]          w_winner;
    int                     w_best;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_data;
    logic                   w_resp_err;

    // Distance from (last+1) mod NUM_REQ; the smallest valid distance wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = NUM_REQ;
        w_addr   = '0;
        w_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] &&
                (((i + 2*NUM_REQ - int'(r_last) - 1) % NUM_REQ) < w_best)) begin
                w_best   = (i + 2*NUM_REQ - int'(r_last) - 1) % NUM_REQ;
                w_winner = IW'(i);
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == w_winner) begin
                w_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_resp_err = bus.write_done ? bus.write_error : 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_last        <= IW'(NUM_REQ - 1);
            r_winner      <= '0;
            r_cnt         <= '0;
            r_error       <= 1'b0;
            r_req_ready   <= '0;
            r_req_done    <= '0;
            r_req_error   <= '0;
            r_write_start <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_busy        <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_req_ready <= '0;
            r_req_done  <= '0;
            r_req_error <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner      <= w_winner;
                        r_last        <= w_winner;
                        r_addr        <= w_addr;
                        r_data        <= w_data;
                        r_req_ready   <= NUM_REQ'(1) << w_winner;
                        r_write_start <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.write_ready) begin
                        r_write_start <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A completion arriving on the expiry cycle beats the timeout.
                    if (bus.write_done || r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_error     <= w_resp_err;
                        r_req_done  <= NUM_REQ'(1) << r_winner;
                        r_req_error <= w_resp_err ? (NUM_REQ'(1) << r_winner) : '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_error && r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.req_done    = r_req_done;
    assign bus.req_error   = r_req_error;
    assign bus.write_start = r_write_start;
    assign bus.write_addr  = r_addr;
    assign bus.write_data  = r_data;
    assign o_busy          = r_busy;
    assign o_err_count     = r_err_count;
endmodule

// File: tb/tb_axi4_write_arbiter.sv
// tb/tb_axi4_write_arbiter.sv - directed self-checking bench for axi4_write_arbiter
module tb_axi4_write_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TO = 8;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] err_count;
    int         n_vec;
    int         n_miss;
    int         n_done;
    int         grant_q[$];
    logic [NR-1:0] d_seen;
    logic [NR-1:0] e_seen;
    int         done_before;

    axi4_write_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_write_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_busy     (busy),
        .o_err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) grant_q.push_back(i);
            end
            if (|bus.req_done) n_done++;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid   = '0;
        bus.write_ready = 1'b0;
        bus.write_done  = 1'b0;
        bus.write_error = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(output logic [NR-1:0] d, output logic [NR-1:0] e);
        d = '0;
        e = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (|bus.req_ready) bus.req_valid = bus.req_valid & ~bus.req_ready;
            if (|bus.req_done) begin
                d = bus.req_done;
                e = bus.req_error;
                return;
            end
        end
        check("wait_done_bound", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        n_done = 0;
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(32'h100 * i + 32'h20);
            bus.req_data[i*DW +: DW] = DW'(32'hF0 + i);
        end
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_start", bus.write_start, 0);

        // single request from requester 2
        bus.req_addr[2*AW +: AW] = 32'h20;
        bus.req_data[2*DW +: DW] = 256'hF2;
        bus.req_valid = 4'b0100;
        tick();
        check("s_ready", bus.req_ready, 4'b0100);
        check("s_start", bus.write_start, 1);
        check("s_addr", bus.write_addr, 32'h20);
        check("s_data", bus.write_data, 256'hF2);
        check("s_busy", busy, 1);
        bus.req_valid = '0;
        tick();
        check("s_ready_once", bus.req_ready, 0);
        check("s_start_hold", bus.write_start, 1);
        bus.write_ready = 1'b1;
        tick();
        check("s_start_wait", bus.write_start, 0);
        bus.write_ready = 1'b0;
        repeat (4) tick();
        check("s_no_early_done", bus.req_done, 0);
        bus.write_done = 1'b1;
        tick();
        check("s_done", bus.req_done, 4'b0100);
        check("s_err", bus.req_error, 0);
        bus.write_done = 1'b0;
        tick();
        check("s_idle_busy", busy, 0);
        check("s_errcnt", err_count, 0);

        // round robin with immediate master, minimum latency
        do_reset();
        grant_q.delete();
        bus.req_valid   = 4'b1111;
        bus.write_ready = 1'b1;
        bus.write_done  = 1'b1;
        tick();
        check("rr_first_ready", bus.req_ready, 4'b0001);
        tick();
        check("rr_start_1cyc", bus.write_start, 0);
        tick();
        check("rr_min_latency", bus.req_done, 4'b0001);
        for (int c = 0; c < 60 && grant_q.size() < 6; c++) tick();
        check("rr_count", grant_q.size() >= 6, 1);
        if (grant_q.size() >= 6) begin
            check("rr_g0", grant_q[0], 0);
            check("rr_g1", grant_q[1], 1);
            check("rr_g2", grant_q[2], 2);
            check("rr_g3", grant_q[3], 3);
            check("rr_g4", grant_q[4], 0);
            check("rr_g5", grant_q[5], 1);
        end

        // error path on requester 1
        do_reset();
        bus.req_valid   = 4'b0010;
        bus.write_ready = 1'b1;
        bus.write_done  = 1'b1;
        bus.write_error = 1'b1;
        wait_done(d_seen, e_seen);
        check("e_done", d_seen, 4'b0010);
        check("e_err", e_seen, 4'b0010);
        tick();
        check("e_errcnt", err_count, 1);

        // timeout with no completion
        do_reset();
        bus.req_valid   = 4'b0001;
        bus.write_ready = 1'b1;
        tick();
        bus.req_valid = '0;
        tick();
        repeat (7) tick();
        check("to_not_early", bus.req_done, 0);
        tick();
        check("to_done", bus.req_done, 4'b0001);
        check("to_err", bus.req_error, 4'b0001);
        tick();
        check("to_errcnt", err_count, 1);

        // completion on the expiry cycle wins
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        tick();
        repeat (7) tick();
        bus.write_done  = 1'b1;
        bus.write_error = 1'b0;
        tick();
        check("tx_done", bus.req_done, 4'b0001);
        check("tx_err", bus.req_error, 0);
        bus.write_done = 1'b0;
        tick();
        check("tx_errcnt", err_count, 1);

        // reset while waiting for the master
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        done_before = n_done;
        rst = 1'b1;
        #1;
        check("rw_busy", busy, 0);
        check("rw_errcnt", err_count, 0);
        check("rw_done", bus.req_done, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rw_no_done", n_done, done_before);
        bus.req_valid   = 4'b1000;
        bus.write_ready = 1'b1;
        bus.write_done  = 1'b1;
        bus.write_error = 1'b0;
        wait_done(d_seen, e_seen);
        check("rw_req3_done", d_seen, 4'b1000);
        check("rw_req3_err", e_seen, 0);
        tick();

        // error counter saturation
        do_reset();
        bus.write_ready = 1'b1;
        bus.write_done  = 1'b1;
        bus.write_error = 1'b1;
        for (int n = 0; n < 260; n++) begin
            bus.req_valid = 4'b0010;
            wait_done(d_seen, e_seen);
            tick();
            if (n == 254) check("sat_255", err_count, 255);
        end
        check("sat_260", err_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/axi4_write_arbiter.md
AXI4_WRITE_ARBITER -- requirements
Module: axi4_write_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, write address width.
- DATA_WIDTH, 256, write data width.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before the arbiter declares a timeout (at least 2).
REQ-002 Ports SHALL be:
- CLOCK  in  1  single clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester write request.
- REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed data; requester i uses slice i.
- REQ_READY  out  NUM_REQ  one-cycle pulse that accepts the request.
- REQ_DONE  out  NUM_REQ  one-cycle completion pulse.
- REQ_ERROR  out  NUM_REQ  error qualifier; valid only while REQ_DONE is high.
- WRITE_START  out  1  write request to the AXI4 master.
- WRITE_ADDR  out  ADDR_WIDTH  address to the master.
- WRITE_DATA  out  DATA_WIDTH  data to the master.
- WRITE_READY  in  1  master accepts the write request.
- WRITE_DONE  in  1  master completion pulse (B channel received).
- WRITE_ERROR  in  1  master error, qualified by WRITE_DONE.
- BUSY  out  1  high in any state other than IDLE.
- ERR_COUNT  out  8  saturating count of errored or timed-out writes.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-004 In IDLE with any REQ_VALID high, the arbiter SHALL pick the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward.
REQ-005 On that edge it SHALL register the winner index, REQ_ADDR slice and REQ_DATA slice, update last_grant, and go to ISSUE.
REQ-006 REQ_READY[winner] SHALL be high for exactly the first ISSUE cycle, one cycle after the request was sampled.
REQ-007 A requester SHALL hold REQ_VALID, REQ_ADDR and REQ_DATA stable until it sees REQ_READY.
REQ-008 A REQ_VALID that drops before it is granted SHALL have no effect.
REQ-009 In ISSUE, WRITE_START SHALL be high with the registered WRITE_ADDR/WRITE_DATA held stable.
REQ-010 The first edge that samples WRITE_READY=1 in ISSUE SHALL move the FSM to WAIT; WRITE_START SHALL be low in WAIT.
REQ-011 If WRITE_READY is already high in the first ISSUE cycle, WRITE_START SHALL last exactly one cycle.
REQ-012 WAIT SHALL run a timeout counter that is cleared on entry and increments each cycle.
REQ-013 WRITE_DONE=1 in WAIT SHALL capture WRITE_ERROR as the error status and move the FSM to RESP.
REQ-014 If the counter reaches TIMEOUT_CYCLES-1 without WRITE_DONE, the FSM SHALL go to RESP with error=1.
REQ-015 WRITE_DONE in the same cycle as timeout expiry SHALL take priority; the error value is then WRITE_ERROR.
REQ-016 WRITE_DONE and WRITE_ERROR SHALL be ignored outside WAIT.
REQ-017 RESP SHALL last one cycle: REQ_DONE[winner]=1, REQ_ERROR[winner]=error, all other bits 0; then the FSM returns to IDLE.
REQ-018 RESP SHALL increment ERR_COUNT when error=1, saturating at 255.
REQ-019 Throughput SHALL be at most one write in flight, with at least one IDLE cycle between transactions.
REQ-020 The minimum transaction is 4 cycles from request sample to REQ_DONE: IDLE, ISSUE, WAIT with WRITE_DONE in its first cycle, then RESP.
REQ-021 No requester SHALL wait more than NUM_REQ-1 grants while its REQ_VALID is held.
REQ-022 The 3-bit index arithmetic SHALL wrap modulo NUM_REQ; NUM_REQ not a power of two SHALL wrap correctly, e.g. NUM_REQ=3 gives 2 then 0.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-024 RESET high SHALL immediately force state IDLE, all outputs 0, ERR_COUNT=0, timeout counter 0, and last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-025 Reset mid-transaction SHALL drop the transaction with no REQ_DONE pulse.
REQ-026 After RESET falls, arbitration SHALL start on the first rising edge at which RESET is low.

Verification
REQ-027 Single request: REQ_VALID[2]=1, addr 0x20, data 0xF2; master WRITE_READY after 2 cycles and WRITE_DONE 5 cycles later -> WRITE_ADDR=0x20, WRITE_DATA=0xF2, one REQ_READY[2] pulse, REQ_DONE[2] with REQ_ERROR[2]=0, ERR_COUNT=0.
REQ-028 Round-robin: all four REQ_VALID held high from reset, with master ready and done always immediate -> grant order 0,1,2,3,0,1.
REQ-029 Error path: WRITE_DONE=1 with WRITE_ERROR=1 for requester 1 -> REQ_DONE[1]=1, REQ_ERROR[1]=1, ERR_COUNT=1.
REQ-030 Timeout (TIMEOUT_CYCLES=8): WRITE_DONE never asserted -> RESP after exactly 8 WAIT cycles with error=1, and ERR_COUNT increments. A separate run asserts WRITE_DONE=1, WRITE_ERROR=0 on the expiry cycle -> error=0.
REQ-031 Reset mid-WAIT: RESET pulsed in the WAIT state -> BUSY=0, no REQ_DONE, ERR_COUNT=0; the next request from requester 3, alone, is granted normally.
REQ-032 Saturation: 260 errored writes -> ERR_COUNT=255.
